// File: rtl/addsub_hexdisp_if.sv
// Operand, control and display bundle for the add/subtract hex-display block.
// The design side takes the slave modport; the stimulus/board side takes master.
interface addsub_hexdisp_if #(
  parameter int WIDTH = 8
);
  localparam int DIGITS = (WIDTH + 3) / 4;

  logic              load;
  logic              mode;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              ci;
  logic              blank_lz;
  logic [WIDTH-1:0]  result;
  logic              co;
  logic              ovf;
  logic              valid;
  logic [6:0]        seg;
  logic [DIGITS-1:0] sel;

  modport master (
    output load, mode, a, b, ci, blank_lz,
    input  result, co, ovf, valid, seg, sel
  );

  modport slave (
    input  load, mode, a, b, ci, blank_lz,
    output result, co, ovf, valid, seg, sel
  );
endinterface

// File: rtl/addsub_hexdisp.sv
// N-bit adder/subtractor with a registered result, carry/borrow and signed overflow,
// driving a time-multiplexed hex seven-segment display with optional leading-zero blanking.
module addsub_hexdisp #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  addsub_hexdisp_if.slave  bus
);
  localparam int DIGITS = (WIDTH + 3) / 4;
  localparam int EXT_W  = 4 * DIGITS;
  localparam int DIV_W  = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] SEL_MSB = DIGITS'(1) << (DIGITS - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      4'hF:    s = 7'b1000111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Subtraction overflows when operand signs differ, addition when they agree;
  // either way the result sign has moved away from a's sign.
  function automatic logic signed_ovf(input logic sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    return (sub ? (a_msb != b_msb) : (a_msb == b_msb)) && (r_msb != a_msb);
  endfunction

  logic [WIDTH:0]     sum_s;
  logic               ovf_nxt_s;
  logic [WIDTH-1:0]   result_r;
  logic               co_r;
  logic               ovf_r;
  logic               valid_r;
  logic [DIV_W-1:0]   div_r;
  logic               tick_s;
  logic [IDX_W-1:0]   idx_r;
  logic [EXT_W-1:0]   ext_s;
  logic [EXT_W-1:0]   shifted_s;
  logic [DIGITS-1:0]  sel_nxt_s;
  logic [6:0]         seg_nxt_s;
  logic [DIGITS-1:0]  sel_r;
  logic [6:0]         seg_r;

  // Arithmetic in WIDTH+1 bits: the extra bit is carry-out for add and borrow-out for subtract.
  always_comb begin
    if (bus.mode) begin
      sum_s = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.ci};
    end else begin
      sum_s = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.ci};
    end
    ovf_nxt_s = signed_ovf(bus.mode, bus.a[WIDTH-1], bus.b[WIDTH-1], sum_s[WIDTH-1]);
  end

  // Result register: captures on load, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= '0;
      co_r     <= 1'b0;
      ovf_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else if (bus.load) begin
      result_r <= sum_s[WIDTH-1:0];
      co_r     <= sum_s[WIDTH];
      ovf_r    <= ovf_nxt_s;
      valid_r  <= 1'b1;
    end
  end

  assign tick_s = (div_r == DIV_W'(DIV));

  // Refresh divider: counts 0..DIV, one tick per DIV+1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Digit selection and decode; the top nibble is zero-extended for non-multiple-of-4 widths.
  always_comb begin
    ext_s     = EXT_W'(result_r);
    shifted_s = ext_s >> {idx_r, 2'b00};
    sel_nxt_s = SEL_MSB >> idx_r;
    if (!valid_r) begin
      seg_nxt_s = 7'b0000000;
    end else if (bus.blank_lz && (idx_r != '0) && (shifted_s == '0)) begin
      seg_nxt_s = 7'b0000000;
    end else begin
      seg_nxt_s = hex_to_seg(shifted_s[3:0]);
    end
  end

  // Scan registers: sel/seg update together on each tick, then the digit index advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= '0;
      sel_r <= '0;
      seg_r <= 7'b0000000;
    end else if (tick_s) begin
      sel_r <= sel_nxt_s;
      seg_r <= seg_nxt_s;
      if (idx_r == IDX_W'(DIGITS - 1)) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end
  end

  assign bus.result = result_r;
  assign bus.co     = co_r;
  assign bus.ovf    = ovf_r;
  assign bus.valid  = valid_r;
  assign bus.sel    = sel_r;
  assign bus.seg    = seg_r;

endmodule
